// File: rtl/mont_pkg.sv
// Shared types and the single Montgomery iteration step for montgomery_mult_serial.
// The step function works at a fixed maximum width; callers zero-extend and slice.
package mont_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CALC    = 2'd1,
        CORRECT = 2'd2,
        DONE    = 2'd3
    } mont_mult_state_t;

    localparam int MONT_MAX_W = 64;

    // One radix-2 iteration: add y when the x bit is set, make the sum even by
    // adding m if needed, then halve. Two headroom bits keep A + y + m from overflowing.
    function automatic logic [MONT_MAX_W+1:0] mont_step(
        input logic [MONT_MAX_W+1:0] a,
        input logic                  xbit,
        input logic [MONT_MAX_W-1:0] y,
        input logic [MONT_MAX_W-1:0] m
    );
        logic [MONT_MAX_W+1:0] s;
        s = a + (xbit ? {2'b00, y} : '0);
        if (s[0]) begin
            s = s + {2'b00, m};
        end
        return s >> 1;
    endfunction

endpackage

// File: rtl/montgomery_mult_serial.sv
// Bit-serial radix-2 Montgomery multiplier: x*y*2^-W mod m, one iteration per clock,
// done W+1 cycles after the start edge. Optional operand checking under MONT_MULT_CHECK_EN.
import mont_pkg::*;

module montgomery_mult_serial #(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    output logic                  done,
    input  logic [WORD_WIDTH-1:0] m,
    input  logic [WORD_WIDTH-1:0] x,
    input  logic [WORD_WIDTH-1:0] y,
    input  logic [WORD_WIDTH:0]   R,
`ifdef MONT_MULT_CHECK_EN
    output logic                  operand_err,
`endif
    output logic [WORD_WIDTH-1:0] mult_result
);

    localparam int W  = WORD_WIDTH;
    localparam int CW = $clog2(WORD_WIDTH);
    localparam int SW = MONT_MAX_W + 2;

    mont_mult_state_t state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W+1:0]     a_q, a_d;
    logic [W-1:0]     xr_q, xr_d;
    logic [W-1:0]     yr_q, yr_d;
    logic [W-1:0]     mr_q, mr_d;
    logic [W-1:0]     mult_result_q, mult_result_d;
    logic             operand_err_q, operand_err_d;

    logic [SW-1:0]    step_full;
    logic [W+1:0]     a_sub;
    logic             bad_operands;
    logic             unused_bits;

`ifdef MONT_MULT_CHECK_EN
    assign bad_operands = ~m[0] || (x >= m) || (y >= m) || (R != {1'b1, {W{1'b0}}});
    assign unused_bits  = ^{step_full[SW-1:W+2], a_sub[W+1:W]};
    assign operand_err  = operand_err_q;
`else
    assign bad_operands = 1'b0;
    assign unused_bits  = ^{R, step_full[SW-1:W+2], a_sub[W+1:W], operand_err_q};
`endif

    assign done        = (state_q == DONE);
    assign mult_result = mult_result_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        a_d           = a_q;
        xr_d          = xr_q;
        yr_d          = yr_q;
        mr_d          = mr_q;
        mult_result_d = mult_result_q;
        operand_err_d = operand_err_q;

        step_full = mont_step(SW'(a_q), xr_q[cnt_q], MONT_MAX_W'(yr_q), MONT_MAX_W'(mr_q));
        a_sub     = a_q - {2'b00, mr_q};

        case (state_q)
            IDLE: begin
                if (enable) begin
                    xr_d          = x;
                    yr_d          = y;
                    mr_d          = m;
                    a_d           = '0;
                    cnt_d         = '0;
                    operand_err_d = 1'b0;
                    state_d       = CALC;
                    // Rejected operands bypass CALC; A stays 0 so CORRECT yields 0.
                    if (bad_operands) begin
                        operand_err_d = 1'b1;
                        mult_result_d = '0;
                        state_d       = CORRECT;
                    end
                end
            end
            CALC: begin
                a_d = step_full[W+1:0];
                if (cnt_q == CW'(W - 1)) begin
                    state_d = CORRECT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CORRECT: begin
                mult_result_d = (a_q >= {2'b00, mr_q}) ? a_sub[W-1:0] : a_q[W-1:0];
                state_d       = DONE;
            end
            DONE: begin
                if (!enable) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            a_q           <= '0;
            xr_q          <= '0;
            yr_q          <= '0;
            mr_q          <= '0;
            mult_result_q <= '0;
            operand_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            a_q           <= a_d;
            xr_q          <= xr_d;
            yr_q          <= yr_d;
            mr_q          <= mr_d;
            mult_result_q <= mult_result_d;
            operand_err_q <= operand_err_d;
        end
    end

endmodule

// File: tb/tb_montgomery_mult_serial.sv
// Directed-vector bench for montgomery_mult_serial (W=32), expected values computed by hand.
module tb_montgomery_mult_serial;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         done;
    logic [W-1:0] m, x, y;
    logic [W:0]   R;
    logic [W-1:0] mult_result;
`ifdef MONT_MULT_CHECK_EN
    logic         operand_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    montgomery_mult_serial #(.WORD_WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .done        (done),
        .m           (m),
        .x           (x),
        .y           (y),
        .R           (R),
`ifdef MONT_MULT_CHECK_EN
        .operand_err (operand_err),
`endif
        .mult_result (mult_result)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands, take the start edge, then count edges until done.
    task automatic start_op(input logic [W-1:0] mm, input logic [W-1:0] xx,
                            input logic [W-1:0] yy);
        m = mm; x = xx; y = yy;
        enable = 1'b1;
        tick();
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_mult(input string tag, input logic [W-1:0] mm, input logic [W-1:0] xx,
                            input logic [W-1:0] yy, input logic [W-1:0] exp);
        int lat;
        start_op(mm, xx, yy);
        wait_done(lat);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_res"}, 64'(mult_result), 64'(exp));
        enable = 1'b0;
        tick();
        check({tag, "_idle"}, 64'(done), 64'd0);
    endtask

    initial begin
        int lat;
        reset = 1'b1; enable = 1'b0;
        m = '0; x = '0; y = '0;
        R = {1'b1, {W{1'b0}}};
        tick(); tick();
        check("rst_done", 64'(done), 64'd0);
        check("rst_res", 64'(mult_result), 64'd0);
        reset = 1'b0;
        tick();

        // 5*7*2^-32 mod 13 = 1; operands scrambled after the start edge must be ignored
        start_op(32'd13, 32'd5, 32'd7);
        m = 32'd3; x = 32'd0; y = 32'd0;
        wait_done(lat);
        check("t1_lat", 64'(lat), 64'd33);
        check("t1_res", 64'(mult_result), 64'd1);
        enable = 1'b0;
        tick();
        check("t1_idle", 64'(done), 64'd0);

        // 2^32 mod 13 = 9, its inverse is 3
        run_mult("mont_one", 32'd13, 32'd9, 32'd9, 32'd9);
        run_mult("x_zero", 32'd13, 32'd0, 32'd7, 32'd0);
        run_mult("one_one", 32'd13, 32'd1, 32'd1, 32'd3);
        run_mult("x12_y12", 32'd13, 32'd12, 32'd12, 32'd3);
        // m = 2^32-1 makes R congruent to 1
        run_mult("max_w", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd1);
        run_mult("max_m_small", 32'hFFFF_FFFF, 32'd5, 32'd7, 32'd35);

        // Reset in the middle of CALC aborts the operation
        start_op(32'd13, 32'd5, 32'd7);
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1; enable = 1'b0;
        tick();
        check("abort_done", 64'(done), 64'd0);
        check("abort_res", 64'(mult_result), 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        check("abort_stays_idle", 64'(done), 64'd0);
        run_mult("restart", 32'd13, 32'd5, 32'd7, 32'd1);

        // Holding enable keeps done high; releasing it returns to IDLE
        start_op(32'd13, 32'd9, 32'd9);
        wait_done(lat);
        check("hold_lat", 64'(lat), 64'd33);
        for (int i = 0; i < 3; i++) tick();
        check("hold_done", 64'(done), 64'd1);
        check("hold_res", 64'(mult_result), 64'd9);
        enable = 1'b0;
        tick();
        check("release_done", 64'(done), 64'd0);

        // enable dropped mid-CALC: operation completes, done is a single-cycle pulse
        start_op(32'd13, 32'd12, 32'd12);
        for (int i = 0; i < 5; i++) tick();
        enable = 1'b0;
        lat = 5;
        while (!done && lat < 200) begin
            tick();
            lat++;
        end
        check("pulse_lat", 64'(lat), 64'd33);
        check("pulse_res", 64'(mult_result), 64'd3);
        tick();
        check("pulse_width", 64'(done), 64'd0);
        check("pulse_res_hold", 64'(mult_result), 64'd3);

`ifdef MONT_MULT_CHECK_EN
        start_op(32'd12, 32'd5, 32'd7);
        wait_done(lat);
        check("err_lat_le2", 64'(lat <= 2), 64'd1);
        check("err_flag", 64'(operand_err), 64'd1);
        check("err_res", 64'(mult_result), 64'd0);
        enable = 1'b0;
        tick();
        run_mult("err_clear", 32'd13, 32'd5, 32'd7, 32'd1);
        check("err_cleared", 64'(operand_err), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
